// File: rtl/eprom_read_ctl_pkg.sv
// Shared definitions for the 2716 EPROM read sequencer: ROM geometry,
// sequencer state encoding and the window-decode helper.
package eprom_read_ctl_pkg;

   localparam int ROM_AW = 11;
   localparam int ROM_DW = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_DONE    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Only the bits above the 2K ROM span take part in the window compare.
   function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
      return addr[15:ROM_AW] == base[15:ROM_AW];
   endfunction

endpackage

// File: rtl/eprom_read_ctl.sv
// Z80-bus read sequencer for one 2716 EPROM: decodes a 2K window, strobes
// CS_N/OE_N, stretches the CPU with WAIT_N and presents the captured byte.
module eprom_read_ctl
   import eprom_read_ctl_pkg::*;
#(
   parameter logic [15:0] BASE       = 16'hF000,
   parameter int          ACC_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       cpu_a,
   input  logic              cpu_mreq_n,
   input  logic              cpu_rd_n,
   output logic              cpu_wait_n,
   output logic [ROM_DW-1:0] cpu_d,
   output logic              cpu_d_oe,
   output logic [ROM_AW-1:0] rom_a,
   output logic              rom_cs_n,
   output logic              rom_oe_n,
   input  logic [ROM_DW-1:0] rom_d
);

   if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc
      $error("eprom_read_ctl: ACC_CYCLES=%0d outside 1..15", ACC_CYCLES);
   end

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [ROM_AW-1:0]  r_rom_a;
   logic [ROM_DW-1:0]  r_cpu_d;
   logic               r_cs_n;
   logic               r_oe_n;
   logic               r_d_oe;
   logic               w_hit;
   logic               w_latch_a;
   logic               w_capture;
   logic               w_cs_n_nxt;
   logic               w_oe_n_nxt;
   logic               w_d_oe_nxt;

   assign w_hit = !cpu_mreq_n && !cpu_rd_n && in_window(cpu_a, BASE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch_a   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_state_nxt = ST_SETUP;
               w_latch_a   = 1'b1;
            end
         end
         ST_SETUP: begin
            if (!w_hit) begin
               w_state_nxt = ST_RECOVER;
            end else begin
               w_state_nxt = ST_ACCESS;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         // An abort takes priority over a capture due on the same edge.
         ST_ACCESS: begin
            if (!w_hit) begin
               w_state_nxt = ST_RECOVER;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!w_hit) begin
               w_state_nxt = ST_RECOVER;
            end
         end
         ST_RECOVER: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they register in step with it.
   always_comb begin
      w_cs_n_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RECOVER);
      w_oe_n_nxt = !((w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_DONE));
      w_d_oe_nxt = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_rom_a <= '0;
         r_cpu_d <= '0;
         r_cs_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_d_oe  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_d_oe  <= w_d_oe_nxt;
         if (w_latch_a) r_rom_a <= cpu_a[ROM_AW-1:0];
         if (w_capture) r_cpu_d <= rom_d;
      end
   end

   assign cpu_wait_n = !(w_hit && ((r_state == ST_IDLE) || (r_state == ST_SETUP) ||
                                   (r_state == ST_ACCESS)));
   assign cpu_d      = r_cpu_d;
   assign cpu_d_oe   = r_d_oe;
   assign rom_a      = r_rom_a;
   assign rom_cs_n   = r_cs_n;
   assign rom_oe_n   = r_oe_n;

endmodule
